// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encodings, addressing mode, instruction
// field geometry and the fetch FSM state type.
package sisc_pkg;

   localparam logic [3:0] NOOP   = 4'd0;
   localparam logic [3:0] LOD    = 4'd1;
   localparam logic [3:0] STR    = 4'd2;
   localparam logic [3:0] SWP    = 4'd3;
   localparam logic [3:0] BRA    = 4'd4;
   localparam logic [3:0] BRR    = 4'd5;
   localparam logic [3:0] BNE    = 4'd6;
   localparam logic [3:0] BNR    = 4'd7;
   localparam logic [3:0] ALU_OP = 4'd8;
   localparam logic [3:0] HLT    = 4'd15;

   localparam logic [3:0] AM_IMM = 4'd8;

   // opcode occupies the top OPCODE_W bits, mm the next MM_W bits,
   // imm the low AW bits of the instruction word
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned MM_W     = 4;
   localparam int unsigned IMM_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ERR  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory read handshake: req/addr out, rdata/ack back.
interface sisc_fetch_unit_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned IW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/sisc_pc_reg.sv
// Program counter with next-PC selection: increment, absolute or relative branch.
module sisc_pc_reg
   import sisc_pkg::*;
#(
   parameter int unsigned AW       = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          pc_rst,
   input  logic          pc_write,
   input  logic          pc_sel,
   input  logic          br_sel,
   input  logic [AW-1:0] imm,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] next_pc;

   // next-PC mux; adders wrap mod 2^AW so imm works as a signed displacement
   always_comb begin
      next_pc = pc + AW'(1);
      if (pc_sel) begin
         next_pc = br_sel ? imm : (pc + imm);
      end
   end

   // PC register: reset > pc_rst > pc_write > hold
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         pc <= AW'(RESET_PC);
      end else if (pc_rst) begin
         pc <= AW'(RESET_PC);
      end else if (pc_write) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, instruction register, imem fetch FSM and watchdog.
module sisc_fetch_unit
   import sisc_pkg::*;
#(
   parameter int unsigned AW       = 16,
   parameter int unsigned IW       = 32,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                   clk,
   input  logic                   rst_f,
   input  logic                   pc_rst,
   input  logic                   pc_write,
   input  logic                   pc_sel,
   input  logic                   br_sel,
   input  logic                   ir_load,
   sisc_fetch_unit_if.master      imem,
   output logic [AW-1:0]          pc,
   output logic [IW-1:0]          ir,
   output logic [OPCODE_W-1:0]    opcode,
   output logic [MM_W-1:0]        mm,
   output logic                   fetch_busy,
   output logic                   imem_err
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   fetch_state_t   state, state_next;
   logic [WDW-1:0] wd;
   logic           start_fetch;
   logic           take_ack;
   logic           time_out;
   logic           wd_last;

   assign wd_last = (wd == WDW'(TIMEOUT - 1));

   sisc_pc_reg #(
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_f    (rst_f),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .imm      (ir[IMM_LSB +: AW]),
      .pc       (pc)
   );

   // fetch FSM state register
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // fetch FSM transitions; pc_rst dominates so it aborts REQ and clears ERR
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (!pc_rst && ir_load) state_next = ST_REQ;
         ST_REQ: begin
            if (pc_rst || imem.imem_ack) state_next = ST_IDLE;
            else if (wd_last)            state_next = ST_ERR;
         end
         ST_ERR:  if (pc_rst) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath enables decoded from the current state
   always_comb begin
      imem.imem_req = (state == ST_REQ);
      fetch_busy    = (state == ST_REQ);
      imem_err      = (state == ST_ERR);
      start_fetch   = (state == ST_IDLE) && ir_load && !pc_rst;
      take_ack      = (state == ST_REQ) && !pc_rst && imem.imem_ack;
      time_out      = (state == ST_REQ) && !pc_rst && !imem.imem_ack && wd_last;
   end

   // fetch address latch, watchdog counter and instruction register
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         imem.imem_addr <= '0;
         wd             <= '0;
         ir             <= '0;
      end else begin
         if (start_fetch) begin
            imem.imem_addr <= pc;
            wd             <= '0;
         end else if (state == ST_REQ && !imem.imem_ack) begin
            wd <= wd + WDW'(1);
         end
         if (take_ack) begin
            ir <= imem.imem_rdata;
         end else if (time_out) begin
            ir <= '0;
         end
      end
   end

   assign opcode = ir[IW-1 -: OPCODE_W];
   assign mm     = ir[IW-OPCODE_W-1 -: MM_W];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed self-checking bench for sisc_fetch_unit.
module tb_sisc_fetch_unit;

   logic        clk;
   logic        rst_f;
   logic        pc_rst;
   logic        pc_write;
   logic        pc_sel;
   logic        br_sel;
   logic        ir_load;
   logic [15:0] pc;
   logic [31:0] ir;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic        fetch_busy;
   logic        imem_err;

   int checks = 0;
   int errors = 0;

   sisc_fetch_unit_if #(.AW(16), .IW(32)) bus ();

   sisc_fetch_unit #(
      .AW       (16),
      .IW       (32),
      .RESET_PC (0),
      .TIMEOUT  (15)
   ) dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .pc_rst     (pc_rst),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .br_sel     (br_sel),
      .ir_load    (ir_load),
      .imem       (bus),
      .pc         (pc),
      .ir         (ir),
      .opcode     (opcode),
      .mm         (mm),
      .fetch_busy (fetch_busy),
      .imem_err   (imem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_f = 1'b0;
      pc_rst = 1'b0; pc_write = 1'b1; pc_sel = 1'b0; br_sel = 1'b0; ir_load = 1'b1;
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
      tick(); tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h, want 0000", pc); end
      checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h, want 00000000", ir); end
      checks++; if (bus.imem_req !== 1'b0 || fetch_busy !== 1'b0 || imem_err !== 1'b0) begin
         errors++; $display("FAIL reset_flags: req=%b busy=%b err=%b, want 0 0 0", bus.imem_req, fetch_busy, imem_err); end
      checks++; if (bus.imem_addr !== 16'h0000 || opcode !== 4'h0 || mm !== 4'h0) begin
         errors++; $display("FAIL reset_fields: addr=%h op=%h mm=%h, want 0000 0 0", bus.imem_addr, opcode, mm); end
      rst_f = 1'b1; pc_write = 1'b0; ir_load = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
   endtask

   task automatic test_zero_wait();
      ir_load = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8100_0005;
      tick();
      ir_load = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || fetch_busy !== 1'b1 || bus.imem_addr !== 16'h0000) begin
         errors++; $display("FAIL zw_req: req=%b busy=%b addr=%h, want 1 1 0000", bus.imem_req, fetch_busy, bus.imem_addr); end
      checks++; if (ir !== 32'h0) begin errors++; $display("FAIL zw_idle_ack: ir=%h, want 00000000", ir); end
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (ir !== 32'h8100_0005) begin errors++; $display("FAIL zw_ir: got %h, want 81000005", ir); end
      checks++; if (opcode !== 4'd8 || mm !== 4'd1) begin errors++; $display("FAIL zw_fields: op=%0d mm=%0d, want 8 1", opcode, mm); end
      checks++; if (fetch_busy !== 1'b0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL zw_done: busy=%b req=%b, want 0 0", fetch_busy, bus.imem_req); end
   endtask

   task automatic test_wait_states();
      int req_cycles;
      req_cycles = 0;
      ir_load = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h1234_5678;
      tick();
      if (bus.imem_req === 1'b1) req_cycles++;
      pc_write = 1'b1; pc_sel = 1'b0;   // pc 0 -> 1 while busy, ir_load still held
      tick();
      pc_write = 1'b0;
      if (bus.imem_req === 1'b1) req_cycles++;
      checks++; if (bus.imem_addr !== 16'h0000 || pc !== 16'h0001) begin
         errors++; $display("FAIL ws_addr_stable: addr=%h pc=%h, want 0000 0001", bus.imem_addr, pc); end
      tick();
      if (bus.imem_req === 1'b1) req_cycles++;
      checks++; if (ir !== 32'h8100_0005 || imem_err !== 1'b0) begin
         errors++; $display("FAIL ws_ir_hold: ir=%h err=%b, want 81000005 0", ir, imem_err); end
      bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0; ir_load = 1'b0;
      if (bus.imem_req === 1'b1) req_cycles++;
      checks++; if (req_cycles !== 3) begin errors++; $display("FAIL ws_req_len_pre: got %0d, want 3", req_cycles); end
      checks++; if (ir !== 32'h1234_5678 || bus.imem_req !== 1'b0 || imem_err !== 1'b0) begin
         errors++; $display("FAIL ws_ir: ir=%h req=%b err=%b, want 12345678 0 0", ir, bus.imem_req, imem_err); end
   endtask

   task automatic fetch_now(input logic [31:0] word);
      ir_load = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = word;
      tick();
      ir_load = 1'b0; bus.imem_ack = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
   endtask

   task automatic test_branch();
      fetch_now(32'h4000_0020);
      checks++; if (opcode !== 4'd4) begin errors++; $display("FAIL br_opcode: got %0d, want 4", opcode); end
      pc_write = 1'b1; pc_sel = 1'b0;
      repeat (4) tick();           // 1 -> 5
      checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL br_inc: got %h, want 0005", pc); end
      pc_sel = 1'b1; br_sel = 1'b1;
      tick();
      checks++; if (pc !== 16'h0020) begin errors++; $display("FAIL br_abs: got %h, want 0020", pc); end
      pc_write = 1'b0;
      fetch_now(32'h5000_FFFE);
      checks++; if (opcode !== 4'd5 || mm !== 4'd0) begin errors++; $display("FAIL br_fields: op=%0d mm=%0d, want 5 0", opcode, mm); end
      pc_rst = 1'b1; tick(); pc_rst = 1'b0;
      pc_write = 1'b1; pc_sel = 1'b0;
      repeat (5) tick();
      pc_sel = 1'b1; br_sel = 1'b0;
      tick();
      pc_write = 1'b0;
      checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL br_rel: got %h, want 0003", pc); end
   endtask

   task automatic test_wrap();
      fetch_now(32'h0000_FFFF);
      pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
      tick();
      checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup: got %h, want ffff", pc); end
      pc_sel = 1'b0;
      tick();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_inc: got %h, want 0000", pc); end
      tick();
      pc_rst = 1'b1;               // pc_rst outranks pc_write
      tick();
      pc_rst = 1'b0; pc_write = 1'b0;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_prio: got %h, want 0000", pc); end
   endtask

   task automatic test_timeout();
      int req_cycles;
      req_cycles = 0;
      ir_load = 1'b1; bus.imem_ack = 1'b0;
      tick();
      ir_load = 1'b0;
      while (bus.imem_req === 1'b1 && req_cycles < 40) begin
         req_cycles++;
         tick();
      end
      checks++; if (req_cycles !== 15) begin errors++; $display("FAIL to_len: got %0d, want 15", req_cycles); end
      checks++; if (imem_err !== 1'b1 || bus.imem_req !== 1'b0 || ir !== 32'h0 || fetch_busy !== 1'b0) begin
         errors++; $display("FAIL to_err: err=%b req=%b ir=%h busy=%b, want 1 0 00000000 0", imem_err, bus.imem_req, ir, fetch_busy); end
      ir_load = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
      pc_write = 1'b1; pc_sel = 1'b0;
      tick(); tick();
      ir_load = 1'b0; bus.imem_ack = 1'b0; pc_write = 1'b0;
      checks++; if (bus.imem_req !== 1'b0 || imem_err !== 1'b1 || ir !== 32'h0 || pc !== 16'h0002) begin
         errors++; $display("FAIL to_ignore: req=%b err=%b ir=%h pc=%h, want 0 1 00000000 0002", bus.imem_req, imem_err, ir, pc); end
      pc_rst = 1'b1;
      tick();
      pc_rst = 1'b0;
      checks++; if (imem_err !== 1'b0 || pc !== 16'h0000 || fetch_busy !== 1'b0) begin
         errors++; $display("FAIL to_clear: err=%b pc=%h busy=%b, want 0 0000 0", imem_err, pc, fetch_busy); end
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL to_idle: req=%b, want 1", bus.imem_req); end
      bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_2222;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (ir !== 32'h1111_2222) begin errors++; $display("FAIL to_refetch: ir=%h, want 11112222", ir); end
   endtask

   task automatic test_back_to_back();
      pc_write = 1'b1; pc_sel = 1'b0;
      tick();
      pc_write = 1'b0;
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      checks++; if (bus.imem_addr !== 16'h0001) begin errors++; $display("FAIL mr_addr: got %h, want 0001", bus.imem_addr); end
      rst_f = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_AAAA;
      tick();
      rst_f = 1'b1; bus.imem_ack = 1'b0;
      checks++; if (ir !== 32'h0 || bus.imem_req !== 1'b0 || pc !== 16'h0000 || bus.imem_addr !== 16'h0000) begin
         errors++; $display("FAIL mr_reset: ir=%h req=%b pc=%h addr=%h, want 00000000 0 0000 0000", ir, bus.imem_req, pc, bus.imem_addr); end
      ir_load = 1'b1;
      tick();
      pc_write = 1'b1; pc_sel = 1'b0;
      tick();
      pc_write = 1'b0;
      checks++; if (bus.imem_addr !== 16'h0000 || pc !== 16'h0001 || bus.imem_req !== 1'b1) begin
         errors++; $display("FAIL b2b_addr: addr=%h pc=%h req=%b, want 0000 0001 1", bus.imem_addr, pc, bus.imem_req); end
      ir_load = 1'b0; pc_rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBBBB_BBBB;
      tick();
      pc_rst = 1'b0;
      checks++; if (bus.imem_req !== 1'b0 || fetch_busy !== 1'b0 || ir !== 32'h0 || pc !== 16'h0000) begin
         errors++; $display("FAIL abort: req=%b busy=%b ir=%h pc=%h, want 0 0 00000000 0000", bus.imem_req, fetch_busy, ir, pc); end
      bus.imem_rdata = 32'hFFFF_0000;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if (ir !== 32'h0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL idle_ack: ir=%h req=%b, want 00000000 0", ir, bus.imem_req); end
   endtask

   initial begin
      rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; ir_load = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_branch();
      test_wrap();
      test_timeout();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Owns the program counter and instruction register for the SISC CPU.
- Sits directly upstream of the control FSM: it supplies opcode/mm and consumes pc_sel, pc_write, pc_rst, ir_load and br_sel.
- Talks to instruction memory over a req/ack handshake that tolerates wait states.
- Has a watchdog that flags a memory access that never completes.

Parameters:
- AW, 16, PC / instruction-memory address width.
- IW, 32, instruction width; opcode = ir[IW-1:IW-4], mm = ir[IW-5:IW-8], imm = ir[AW-1:0].
- RESET_PC, 0, PC value after rst_f or pc_rst.
- TIMEOUT, 15, max cycles to wait for imem_ack before imem_err is raised.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_f  in  1  synchronous, active-low reset.
- pc_rst  in  1  from ctrl: synchronous PC clear to RESET_PC.
- pc_write  in  1  from ctrl: update PC this cycle.
- pc_sel  in  1  from ctrl: 0 = PC+1, 1 = branch target.
- br_sel  in  1  from ctrl: 1 = absolute target (imm), 0 = relative (PC+imm).
- ir_load  in  1  from ctrl: start fetch of instruction at current PC.
- imem_rdata  in  IW  instruction memory read data.
- imem_ack  in  1  memory: rdata valid this cycle.
- imem_req  out  1  memory read request, held until ack.
- imem_addr  out  AW  read address, stable while imem_req=1.
- pc  out  AW  current program counter.
- ir  out  IW  instruction register.
- opcode  out  4  ir opcode field, to ctrl.
- mm  out  4  ir mm field, to ctrl.
- fetch_busy  out  1  fetch in progress.
- imem_err  out  1  sticky: watchdog expired.

Behaviour:
- Reset (rst_f=0 at posedge):
  - pc=RESET_PC, ir=0 (opcode=0=NOOP, mm=0).
  - imem_req=0, imem_addr=0, fetch_busy=0, imem_err=0, watchdog=0, state=IDLE.
  - Reset wins over every other input.
- PC update priority per posedge: rst_f=0 > pc_rst=1 > pc_write=1 > hold.
  - pc_write with pc_sel=0: pc <= pc+1, mod 2^AW (wraps 0xFFFF->0x0000).
  - pc_write with pc_sel=1, br_sel=1: pc <= imm.
  - pc_write with pc_sel=1, br_sel=0: pc <= pc + imm, unsigned mod 2^AW, so imm acts as two's-complement displacement.
  - imm comes from the current ir, not from imem_rdata.
- Fetch FSM states: IDLE, REQ, ERR.
  - IDLE: on ir_load=1, latch imem_addr <= pc (value before any same-cycle pc_write), set imem_req=1 and fetch_busy=1, clear watchdog, go to REQ.
  - REQ with imem_ack=1: ir <= imem_rdata, imem_req=0, fetch_busy=0, go to IDLE. opcode/mm are valid the cycle after ack.
  - REQ with imem_ack=0: watchdog+1. When watchdog reaches TIMEOUT: imem_req=0, imem_err=1, ir <= 0 (NOOP), go to ERR.
  - ERR: fetch_busy=0; ir_load is ignored. Leave ERR only via rst_f or pc_rst, both of which clear imem_err and return to IDLE.
- Latency with zero-wait memory (ack in the first REQ cycle): ir_load at edge N, imem_req high after N, ack sampled at N+1, ir valid after N+1. Each wait state adds 1 cycle.
- ir_load while fetch_busy=1 is ignored; imem_addr does not change mid-request.
- imem_ack while in IDLE or ERR is ignored; ir is unchanged.
- pc_write during REQ updates pc but not imem_addr.
- pc_rst during REQ aborts the fetch: imem_req=0, go to IDLE, ir unchanged.
- opcode/mm are pure slices of ir; they change only when ir is loaded or cleared.

Decomposition:
- Shared package sisc_pkg: opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15), am_imm=8, and field position constants for opcode/mm/imm.
- One natural sub-module, sisc_pc_reg: PC register plus next-PC mux and adder.
- Fetch FSM, watchdog and IR live in the top module.

Test Plan:
- Reset, then ir_load, imem_ack same cycle with rdata=0x8100_0005 -> imem_addr=0x0000; after ack ir=0x81000005, opcode=8, mm=1, fetch_busy=0.
- Three wait states -> imem_req held 4 cycles, imem_addr stable at 0x0000, ir loads on the ack cycle, no imem_err.
- ir=0x4000_0020, pc=0x0005, pc_write=1, pc_sel=1, br_sel=1 -> pc=0x0020. With br_sel=0, ir imm=0xFFFE -> pc=0x0003.
- pc=0xFFFF, pc_write=1, pc_sel=0 -> pc=0x0000.
- No ack for TIMEOUT=15 cycles -> imem_err=1, imem_req=0, ir=0; later ir_load ignored; pc_rst=1 -> imem_err=0, pc=RESET_PC, state IDLE.
- rst_f=0 mid-REQ with imem_ack=1 the same cycle -> ir stays 0, imem_req=0, pc=0; a second ir_load during busy leaves imem_addr unchanged.
